// File: rtl/nsa_pkg.sv
// nsa_pkg: shared slice width and controller state type for nibble_serial_add_ctrl
package nsa_pkg;
    localparam int SLICE_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/nibble_serial_add_ctrl_adder.sv
// adder: 4-bit Kogge-Stone prefix adder
//   a, b  in  4   operands
//   cin   in  1   carry-in
//   sum   out 4   a + b + cin (low 4 bits)
//   cout  out 1   carry-out
module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] g;
    logic [4:0] p;
    // cin is folded in as a generate at position 0, so g[i] ends up as the carry into bit i
    always_comb begin
        g = {a & b, cin};
        p = {a ^ b, 1'b0};
        for (int d = 1; d < 5; d = d * 2)
            for (int i = 4; i >= d; i--) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
    end
    assign sum  = a ^ b ^ g[3:0];
    assign cout = g[4];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add through one 4-bit adder, one slice per cycle, LSB first
//   clk, rst (async, active-high)
//   in_valid/in_ready, in_a, in_b, in_cin   request handshake and operands
//   out_valid/out_ready, out_sum, out_cout  result handshake and result
//   busy                                    high in RUN or DONE
//   NSA_SUB_EN: adds op_sub input; op_sub=1 computes in_a - in_b - in_cin (out_cout=1 means no borrow)
module nibble_serial_add_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef NSA_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW = $clog2(NSLICE);

    state_t               state;
    state_t               state_d;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     result;
    logic [IW-1:0]        idx;
    logic                 carry;
    logic [SLICE_W-1:0]   s;
    logic                 co;
    logic                 accept;
    logic                 last;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign accept    = in_valid && in_ready;
    assign last      = idx == IW'(NSLICE - 1);
    assign out_sum   = result;

    adder u_adder (
        .a    (a_reg[SLICE_W*idx +: SLICE_W]),
        .b    (b_reg[SLICE_W*idx +: SLICE_W]),
        .cin  (carry),
        .sum  (s),
        .cout (co)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_d;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = accept ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            result   <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            out_cout <= 1'b0;
        end else if (accept) begin
            a_reg  <= in_a;
`ifdef NSA_SUB_EN
            // a - b - cin == a + ~b + ~cin in two's complement
            b_reg  <= op_sub ? ~in_b : in_b;
            carry  <= in_cin ^ op_sub;
`else
            b_reg  <= in_b;
            carry  <= in_cin;
`endif
            idx    <= '0;
            result <= '0;
        end else if (state == RUN) begin
            result[SLICE_W*idx +: SLICE_W] <= s;
            carry <= co;
            idx   <= idx + 1'b1;
            if (last) out_cout <= co;
        end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed table-driven bench for nibble_serial_add_ctrl (WIDTH=16)
module tb_nibble_serial_add_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
`ifdef NSA_SUB_EN
    logic         op_sub;
`endif

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef NSA_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 0);
        chk({tag, " in_ready"}, 32'(in_ready), 1);
        chk({tag, " busy"}, 32'(busy), 0);
    endtask

    task automatic start_op(input vec_t v);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready before request", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_cin   = v.cin;
`ifdef NSA_SUB_EN
        op_sub   = v.sub;
`endif
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy after accept", 32'(busy), 1);
        chk("in_ready in RUN", 32'(in_ready), 0);
    endtask

    // edges counted from the accept edge until out_valid is seen
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input vec_t v);
        int n;
        start_op(v);
        wait_done(n);
        chk("latency", 32'(n), 4);
        chk("out_sum", 32'(out_sum), 32'(v.sum));
        chk("out_cout", 32'(out_cout), 32'(v.cout));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        idle_checks("after handshake");
    endtask

    initial begin
        vec_t v;
        int   n;
        logic [W-1:0] held_sum;
        logic         held_cout;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
`ifdef NSA_SUB_EN
        op_sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        idle_checks("reset");
        chk("reset out_sum", 32'(out_sum), 0);
        chk("reset out_cout", 32'(out_cout), 0);
        rst = 1'b0;
        @(negedge clk);
        idle_checks("idle after reset");

        vecs.push_back('{a:16'h1234, b:16'h4321, cin:1'b0, sub:1'b0, sum:16'h5555, cout:1'b0});
        vecs.push_back('{a:16'hFFFF, b:16'h0001, cin:1'b0, sub:1'b0, sum:16'h0000, cout:1'b1});
        vecs.push_back('{a:16'h7FFF, b:16'h0000, cin:1'b1, sub:1'b0, sum:16'h8000, cout:1'b0});
        vecs.push_back('{a:16'hFFFF, b:16'hFFFF, cin:1'b1, sub:1'b0, sum:16'hFFFF, cout:1'b1});
        vecs.push_back('{a:16'h8000, b:16'h8000, cin:1'b0, sub:1'b0, sum:16'h0000, cout:1'b1});
        vecs.push_back('{a:16'h0F0F, b:16'h00F1, cin:1'b0, sub:1'b0, sum:16'h1000, cout:1'b0});
        vecs.push_back('{a:16'h0000, b:16'h0000, cin:1'b0, sub:1'b0, sum:16'h0000, cout:1'b0});
`ifdef NSA_SUB_EN
        vecs.push_back('{a:16'h1000, b:16'h0001, cin:1'b0, sub:1'b1, sum:16'h0FFF, cout:1'b1});
        vecs.push_back('{a:16'h0000, b:16'h0001, cin:1'b0, sub:1'b1, sum:16'hFFFF, cout:1'b0});
        vecs.push_back('{a:16'h0005, b:16'h0003, cin:1'b1, sub:1'b1, sum:16'h0001, cout:1'b1});
`endif
        foreach (vecs[i]) run_op(vecs[i]);

        // backpressure: result must hold and new requests must be refused while DONE
        v = '{a:16'hABCD, b:16'h1111, cin:1'b0, sub:1'b0, sum:16'hBCDE, cout:1'b0};
        start_op(v);
        wait_done(n);
        chk("bp latency", 32'(n), 4);
        held_sum  = out_sum;
        held_cout = out_cout;
        chk("bp out_sum", 32'(held_sum), 32'hBCDE);
        in_valid = 1'b1;
        in_a     = 16'h5A5A;
        in_b     = 16'h0F0F;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp out_valid held", 32'(out_valid), 1);
            chk("bp in_ready low", 32'(in_ready), 0);
            chk("bp out_sum stable", 32'(out_sum), 32'(held_sum));
            chk("bp out_cout stable", 32'(out_cout), 32'(held_cout));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        idle_checks("bp release");
        run_op('{a:16'h0102, b:16'h0304, cin:1'b1, sub:1'b0, sum:16'h0407, cout:1'b0});

        // reset pulsed during RUN at idx=2 aborts the operation
        start_op('{a:16'h1111, b:16'h2222, cin:1'b0, sub:1'b0, sum:16'h3333, cout:1'b0});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        idle_checks("abort");
        chk("abort out_sum", 32'(out_sum), 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("abort no out_valid", 32'(n), 0);
        run_op('{a:16'h0001, b:16'h0001, cin:1'b0, sub:1'b0, sum:16'h0002, cout:1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
